// File: rtl/imm_extend_unit.sv
// Immediate/field extender with a valid/ready handshake and a 2-entry registered output buffer.
// out_data/out_mode are driven straight from the head register; in_ready depends only on count.
module imm_extend_unit #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int FIELD_W   = 5,
  parameter int SHIFT_AMT = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  logic [1:0]         count;
  logic [OUT_W-1:0]   head;
  logic [OUT_W-1:0]   tail;
  logic [1:0]         head_mode;
  logic [1:0]         tail_mode;
  logic [OUT_W-1:0]   result;
  logic [FIELD_W-1:0] field;
  logic               push;
  logic               pop;

  assign field = in_data[FIELD_W-1:0];

  // Size casts of signed operands sign-extend, which also covers IN_W == OUT_W cleanly.
  always_comb begin
    result = '0;
    unique case (in_mode)
      2'b00:   result = OUT_W'(signed'(in_data));
      2'b01:   result = OUT_W'(in_data);
      2'b10:   result = OUT_W'(in_data) << SHIFT_AMT;
      default: result = OUT_W'(signed'(field));
    endcase
  end

  assign in_ready  = !Rst && (count < 2'd2);
  assign out_valid = !Rst && (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = head;
  assign out_mode  = head_mode;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count     <= 2'd0;
      head      <= '0;
      tail      <= '0;
      head_mode <= 2'b00;
      tail_mode <= 2'b00;
    end else begin
      unique case (count)
        2'd0: begin
          if (push) begin
            head      <= result;
            head_mode <= in_mode;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head      <= result;
            head_mode <= in_mode;
          end else if (push) begin
            tail      <= result;
            tail_mode <= in_mode;
            count     <= 2'd2;
          end else if (pop) begin
            count     <= 2'd0;
          end
        end
        2'd2: begin
          // in_ready is low here, so only a pop can happen
          if (pop) begin
            head      <= tail;
            head_mode <= tail_mode;
            count     <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit: modes, back-pressure, push+pop streaming, reset, parameter sweep.
module tb_imm_extend_unit;

  logic        Clk;
  logic        Rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode, out_mode;
  logic [31:0] out_data;

  logic        v5, r5, ov5, or5;
  logic [4:0]  d5;
  logic [1:0]  m5, om5;
  logic [31:0] od5;

  logic        v16, r16, ov16, or16;
  logic [15:0] d16, od16;
  logic [1:0]  m16, om16;

  int n_vec  = 0;
  int n_miss = 0;

  imm_extend_unit dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  imm_extend_unit #(.IN_W(5), .OUT_W(32), .FIELD_W(5), .SHIFT_AMT(16)) dut5 (
    .Clk(Clk), .Rst(Rst), .in_valid(v5), .in_ready(r5),
    .in_data(d5), .in_mode(m5), .out_valid(ov5),
    .out_ready(or5), .out_data(od5), .out_mode(om5)
  );

  imm_extend_unit #(.IN_W(16), .OUT_W(16), .FIELD_W(5), .SHIFT_AMT(8)) dut16 (
    .Clk(Clk), .Rst(Rst), .in_valid(v16), .in_ready(r16),
    .in_data(d16), .in_mode(m16), .out_valid(ov16),
    .out_ready(or16), .out_data(od16), .out_mode(om16)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk)
    if (!Rst) check_val("count_range", 64'(dut.count <= 2'd2), 64'd1);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] mv_data [5] = '{16'h8001, 16'h8001, 16'h8001, 16'h0013, 16'h000F};
  logic [1:0]  mv_mode [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
  logic [31:0] mv_exp  [5] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFFFFF3, 32'h0000000F};

  initial begin
    Rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; in_mode = 2'b00; out_ready = 1'b0;
    v5 = 1'b0; d5 = '0; m5 = 2'b00; or5 = 1'b0;
    v16 = 1'b0; d16 = '0; m16 = 2'b00; or16 = 1'b0;

    // reset held two cycles with a word offered
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_out_data", 64'(out_data), 64'd0);
      check_val("rst_in_ready", 64'(in_ready), 64'd0);
      check_val("rst_out_mode", 64'(out_mode), 64'd0);
    end
    Rst = 1'b0; in_valid = 1'b0;
    #1;
    check_val("post_rst_in_ready", 64'(in_ready), 64'd1);

    // one result per mode, back to back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = mv_data[i]; in_mode = mv_mode[i];
      step();
      check_val("mode_valid", 64'(out_valid), 64'd1);
      check_val("mode_data", 64'(out_data), 64'(mv_exp[i]));
      check_val("mode_mode", 64'(out_mode), 64'(mv_mode[i]));
    end
    in_valid = 1'b0;
    step();
    check_val("drain_valid", 64'(out_valid), 64'd0);

    // back-pressure: A, B fill the buffer, C waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0001; in_mode = 2'b00;
    step();
    check_val("bp_ready_cnt1", 64'(in_ready), 64'd1);
    in_data = 16'h0002;
    step();
    check_val("bp_ready_full", 64'(in_ready), 64'd0);
    check_val("bp_head_a", 64'(out_data), 64'h1);
    in_data = 16'h0003;
    step();
    check_val("bp_hold_data", 64'(out_data), 64'h1);
    check_val("bp_hold_count", 64'(dut.count), 64'd2);
    out_ready = 1'b1;
    step();
    check_val("bp_pop_b", 64'(out_data), 64'h2);
    check_val("bp_ready_again", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_val("bp_pop_c", 64'(out_data), 64'h3);
    check_val("bp_cnt_c", 64'(dut.count), 64'd1);
    step();
    check_val("bp_empty", 64'(out_valid), 64'd0);

    // streaming push+pop at count 1
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 16'(i); in_mode = 2'b01;
      step();
      check_val("stream_data", 64'(out_data), 64'(i));
      check_val("stream_valid", 64'(out_valid), 64'd1);
      check_val("stream_count", 64'(dut.count), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check_val("stream_drain", 64'(dut.count), 64'd0);

    // reset with a full buffer and out_ready high
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011; in_mode = 2'b00;
    step();
    in_data = 16'h0022;
    step();
    check_val("mrst_full", 64'(dut.count), 64'd2);
    in_valid = 1'b0; Rst = 1'b1; out_ready = 1'b1;
    step();
    check_val("mrst_valid", 64'(out_valid), 64'd0);
    check_val("mrst_count", 64'(dut.count), 64'd0);
    check_val("mrst_data", 64'(out_data), 64'd0);
    Rst = 1'b0;
    #1;
    check_val("mrst_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = 16'h0033; in_mode = 2'b00;
    step();
    in_valid = 1'b0;
    check_val("mrst_next_data", 64'(out_data), 64'h33);
    check_val("mrst_next_count", 64'(dut.count), 64'd1);
    step();
    check_val("mrst_next_drain", 64'(out_valid), 64'd0);

    // parameter sweep instances
    or5 = 1'b1; or16 = 1'b1;
    v5 = 1'b1; d5 = 5'b10110; m5 = 2'b00;
    v16 = 1'b1; d16 = 16'h8000; m16 = 2'b00;
    step();
    check_val("w5_sign", 64'(od5), 64'hFFFFFFF6);
    check_val("w5_valid", 64'(ov5), 64'd1);
    check_val("w16_sign", 64'(od16), 64'h8000);
    d5 = 5'b10110; m5 = 2'b01;
    d16 = 16'h0012; m16 = 2'b10;
    step();
    check_val("w5_zero", 64'(od5), 64'h00000016);
    check_val("w16_shift", 64'(od16), 64'h1200);
    d16 = 16'h0010; m16 = 2'b11;
    v5 = 1'b0;
    step();
    check_val("w16_field", 64'(od16), 64'hFFF0);
    check_val("w16_mode", 64'(om16), 64'd3);
    v16 = 1'b0;
    step();
    check_val("w16_drain", 64'(ov16), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
Parametrised immediate/field extender with a valid/ready handshake and a 2-entry output buffer. It is the pipelined successor of the fixed 5-bit sign extender.
- Sits between instruction decode and the ID/EX register.
- Converts an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper-shift, narrow-field sign.
- Results are registered so downstream stalls never stall decode combinationally.

Parameters:
IN_W, 16, width of the in_data immediate field
OUT_W, 32, width of the extended result; OUT_W >= IN_W required
FIELD_W, 5, width of the low sub-field used by mode 3 (shamt-style); 1 <= FIELD_W <= IN_W
SHIFT_AMT, 16, left shift applied in mode 2; 0 <= SHIFT_AMT < OUT_W

Ports:
Clk  input  1  rising-edge clock, sole clock domain
Rst  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word on in_data/in_mode
in_ready  output  1  unit can accept a word this cycle
in_data  input  IN_W  raw immediate
in_mode  input  2  00 sign, 01 zero, 10 upper-shift, 11 field-sign
out_valid  output  1  out_data holds a valid result
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  OUT_W  extended result (head of buffer)
out_mode  output  2  mode that produced out_data

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Rst), sampled only on the rising edge of Clk.
- Reset values:
  - count = 0, both buffer entries = 0.
  - out_valid = 0, out_data = 0, out_mode = 00.
  - in_ready = 0 while Rst = 1.
- Reset mid-operation discards all buffered entries. No output handshake completes in the reset cycle.
- Arithmetic, evaluated on the accepted word:
  - mode 00: sign-extend in_data[IN_W-1] into bits OUT_W-1..IN_W.
  - mode 01: zero-fill bits OUT_W-1..IN_W.
  - mode 10: zero-extend in_data to OUT_W, shift left by SHIFT_AMT, truncate to OUT_W; low SHIFT_AMT bits = 0.
  - mode 11: take in_data[FIELD_W-1:0] and sign-extend bit FIELD_W-1 to OUT_W; upper in_data bits are ignored.
  - in_mode is captured alongside the result and reported on out_mode.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = !Rst & (count < 2). It is a function of registered count only, with no combinational path from out_ready.
  - out_valid = (count != 0). out_data and out_mode come straight from the head register (no combinational logic after the flop).
  - Producer must hold in_data/in_mode stable while in_valid=1 and in_ready=0. The consumer sees out_data stable while out_valid=1 and out_ready=0.
- Latency: a word pushed in cycle N is on out_data with out_valid=1 in cycle N+1 when the buffer was empty. Sustained throughput is 1 word/cycle when out_ready is held high.
- Buffer: 2-entry FIFO (head, tail), strict arrival order, count in 0..2.
  - count 0, push: head <= result, count 1.
  - count 1, push only: tail <= result, count 2.
  - count 1, pop only: count 0.
  - count 1, push+pop: head <= result, count stays 1.
  - count 2, pop: head <= tail, count 1. No push is possible because in_ready=0.
  - count 2, out_ready=0: hold everything.
  - count 0, out_ready asserted: no effect.
- No overflow or underflow is possible by construction. The bench asserts count never leaves 0..2.

Test Plan:
- Reset: Rst=1 for 2 cycles while in_valid=1, in_data=16'hFFFF -> out_valid=0, out_data=0, in_ready=0. The cycle after Rst drops, in_ready=1.
- Modes, with out_ready=1:
  - 16'h8001 mode 00 -> 32'hFFFF8001 next cycle.
  - mode 01 -> 32'h00008001.
  - mode 10 -> 32'h80010000.
  - 16'h0013 mode 11 -> 32'hFFFFFFF3.
  - 16'h000F mode 11 -> 32'h0000000F.
- Back-pressure: out_ready=0, push A=16'h0001, B=16'h0002 (mode 00) -> in_ready=0 after the second push. Word C is held unaccepted. Raise out_ready -> outputs 1, 2, then C, in order, no loss or duplication.
- Simultaneous push+pop at count 1 for 10 cycles with ascending data 0..9 -> out_data 0..9 on consecutive cycles, count stays 1, out_valid continuously 1.
- Reset mid-operation: fill both entries, assert Rst for 1 cycle with out_ready=1 -> no pop completes, out_valid=0, count=0. The next push appears alone one cycle later.
- Parameter sweep:
  - IN_W=5, OUT_W=32, FIELD_W=5, in_data 5'b10110 mode 00 -> 32'hFFFFFFF6.
  - IN_W=OUT_W=16, 16'h8000 mode 00 -> 16'h8000 (no extension bits).
